dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// - Responder (target) side of the pipelined CPU's data-memory port (MemRead/MemWrite/addr/wd/rd).
// - Models a word-addressed SRAM with configurable multi-cycle access latency.
// - Returns a busy (stall) indication that the pipeline's MEM stage uses to freeze, and a one-cycle ack on completion.
// - Sits between the EX_MEM register outputs and the MEM_WB register inputs.
// PARAMETERS
// - DEPTH_WORDS  256  number of 32-bit words; power of two, >=4
// - LATENCY      2    cycles from request acceptance to ack; 1..15
// PORTS
// - clk       in   1   rising-edge clock
// - reset     in   1   synchronous, active-high reset
// - MemRead   in   1   read request level
// - MemWrite  in   1   write request level
// - addr      in   32  byte address; word index = addr[AW+1:2], AW=log2(DEPTH_WORDS)
// - wd        in   32  write data
// - rd        out  32  read data; registered, holds last completed read
// - rd_valid  out  1   1-cycle pulse: rd updated by a completing read
// - ack       out  1   1-cycle pulse: any access (read or write) completed
// - busy      out  1   registered; 1 while an access is in flight; CPU stalls on it
// - err       out  1   1-cycle misalignment pulse (DMEM_MISALIGN_TRAP_EN only; tied 0 otherwise)
// BEHAVIOUR
// - Reset (sync, active-high): state=IDLE, rd=0, rd_valid=0, ack=0, busy=0, err=0, wait counter=0.
//   The array is not cleared. Reset mid-access aborts it: a pending write is discarded and no ack is given.
// - FSM states:
//   - IDLE: no access in flight.
//   - WAIT: counting down LATENCY-1 cycles.
//   - DONE: completion cycle.
// - Accept: on an edge where state is IDLE or DONE and (MemRead|MemWrite)=1.
//   - addr, wd and the op type are captured.
//   - Next state is WAIT with cnt=LATENCY-1, or DONE directly if LATENCY=1.
// - WAIT: cnt decrements each cycle. When cnt reaches 1, next state is DONE.
//   Inputs are ignored while in WAIT; the CPU must hold them.
// - Entering DONE (registered outputs):
//   - write: mem[idx] <= captured wd.
//   - read: rd <= mem[idx] and rd_valid=1.
//   - ack=1 for exactly one cycle.
// - Leaving DONE: goes to IDLE if no new request; otherwise a new request is accepted (back-to-back, no bubble).
// - busy=1 exactly while state==WAIT. For LATENCY=1, busy never rises.
// - Total latency: accept edge at cycle 0 gives ack high during cycle LATENCY.
// - MemRead & MemWrite both 1: treated as a write; rd_valid stays 0.
// - Address wrap: upper bits above AW+1 are ignored, so addr=DEPTH_WORDS*4 aliases word 0.
// - Read-after-write to the same word, back-to-back: the read returns the newly written data.
//   The write commits on entering DONE, before the read samples.
// CONFIGURATION
// - DMEM_MISALIGN_TRAP_EN defined:
//   - an accepted request with addr[1:0]!=0 goes straight to DONE next cycle (no WAIT);
//   - err=1 and ack=1; no write occurs; rd unchanged; rd_valid=0.
// - DMEM_MISALIGN_TRAP_EN undefined: addr[1:0] is ignored and err is tied 0.
// TESTING
// - Reset, then write 0xDEADBEEF to 0x10 (LATENCY=2):
//   busy=1 for 1 cycle, ack at cycle 2; a later read of 0x10 gives rd=0xDEADBEEF with rd_valid pulse.
// - Back-to-back write 0x11111111 @0x20, then read @0x20 issued in the DONE cycle:
//   no idle gap; rd=0x11111111 exactly LATENCY cycles after the read is accepted.
// - Assert reset during WAIT of a write 0xCAFEF00D @0x40:
//   no ack; busy=0 next cycle; a subsequent read of 0x40 returns the prior contents.
// - DEPTH_WORDS=256, write 0xA5A5A5A5 @0x400:
//   a read of 0x000 returns 0xA5A5A5A5 (wrap).
// - MemRead=MemWrite=1, addr 0x8, wd 0x5:
//   write performed, rd_valid=0, ack=1; a following read of 0x8 gives 0x5.
// - With DMEM_MISALIGN_TRAP_EN, write @0x13:
//   err=ack=1 one cycle after accept; mem[4] unchanged; without the macro, the write lands in mem[4].

Source files
------------

// File: rtl/dmem_responder_if.sv
// Data-memory port bundle between the CPU MEM stage (master) and dmem_responder (slave).
interface dmem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        rd_valid;
  logic        ack;
  logic        busy;
  logic        err;

  modport master (
    output MemRead, MemWrite, addr, wd,
    input  rd, rd_valid, ack, busy, err
  );

  modport slave (
    input  MemRead, MemWrite, addr, wd,
    output rd, rd_valid, ack, busy, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed SRAM responder with multi-cycle latency, busy stall and one-cycle ack.
// Optional misalignment trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state;
  state_t        next_state;
  logic [3:0]    cnt;
  logic [3:0]    next_cnt;

  logic [AW-1:0] cap_idx;
  logic [31:0]   cap_wd;
  logic          cap_write;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   rd_q;
  logic          rd_valid_q;
  logic          ack_q;
  logic          busy_q;
  logic          err_q;

  logic          accept;
  logic          req_mis;
  logic          enter_done;
  logic          op_write;
  logic          op_mis;
  logic [AW-1:0] op_idx;
  logic [31:0]   op_wd;
  logic          do_write;
  logic          do_read;
  logic          unused_addr_bits;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign req_mis = (bus.addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};

  // The op that completes this edge comes from the bus when it is accepted
  // straight into DONE, otherwise from the captured request.
  always_comb begin
    accept     = ((state == IDLE) || (state == DONE)) && (bus.MemRead || bus.MemWrite);
    next_state = state;
    next_cnt   = cnt;
    enter_done = 1'b0;
    op_write   = cap_write;
    op_idx     = cap_idx;
    op_wd      = cap_wd;
    op_mis     = 1'b0;
    case (state)
      IDLE, DONE: begin
        next_state = IDLE;
        if (accept) begin
          op_write = bus.MemWrite;
          op_idx   = bus.addr[AW+1:2];
          op_wd    = bus.wd;
          op_mis   = req_mis;
          if (req_mis || (LATENCY == 1)) begin
            next_state = DONE;
            enter_done = 1'b1;
          end else begin
            next_state = WAIT;
            next_cnt   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        next_cnt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          next_state = DONE;
          enter_done = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    do_write = enter_done && op_write && !op_mis;
    do_read  = enter_done && !op_write && !op_mis;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q       <= 32'd0;
      rd_valid_q <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ack_q      <= enter_done;
      rd_valid_q <= do_read;
      err_q      <= enter_done && op_mis;
      busy_q     <= (next_state == WAIT);
      if (do_read) begin
        rd_q <= mem[op_idx];
      end
      if (accept) begin
        cap_idx   <= bus.addr[AW+1:2];
        cap_wd    <= bus.wd;
        cap_write <= bus.MemWrite;
      end
    end
  end

  // Reset wins over a completing write so an aborted access never lands.
  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      mem[op_idx] <= op_wd;
    end
  end

  assign bus.rd       = rd_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.ack      = ack_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against an array-based memory model.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk;
  logic reset;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_rd;
  int          errors;
  int          checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int wordIndex(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // Drop the request for one cycle and confirm all pulses have ended.
  task automatic idleBus();
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_ack", 32'(bus.ack), 32'd0);
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);
    checkOutput("idle_rd_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("idle_rd_hold", bus.rd, exp_rd);
  endtask

  // Present one request, hold it until ack, then compare against the model.
  // Leaves the request asserted so the caller may chain a back-to-back access.
  task automatic applyStimulus(input bit rdq, input bit wrq, input logic [31:0] a, input logic [31:0] d);
    int cycles;
    int busy_cnt;
    int exp_lat;
    bit mis;
    bit exp_valid;
    mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (a % 4) != 0;
`endif
    exp_lat      = mis ? 1 : LAT;
    bus.MemRead  = rdq;
    bus.MemWrite = wrq;
    bus.addr     = a;
    bus.wd       = d;
    cycles       = 0;
    busy_cnt     = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.busy) busy_cnt++;
    end while (!bus.ack && cycles < 40);
    exp_valid = 1'b0;
    if (!mis) begin
      if (wrq) begin
        model_mem[wordIndex(a)] = d;
      end else begin
        exp_rd    = model_mem[wordIndex(a)];
        exp_valid = 1'b1;
      end
    end
    checkOutput("ack_latency", 32'(cycles), 32'(exp_lat));
    checkOutput("busy_cycles", 32'(busy_cnt), 32'(exp_lat - 1));
    checkOutput("rd_valid", 32'(bus.rd_valid), 32'(exp_valid));
    checkOutput("err", 32'(bus.err), 32'(mis));
    checkOutput("rd", bus.rd, exp_rd);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          op;
    errors       = 0;
    checks       = 0;
    exp_rd       = 32'd0;
    reset        = 1'b1;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.addr     = 32'd0;
    bus.wd       = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rd", bus.rd, 32'd0);
    checkOutput("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("reset_ack", 32'(bus.ack), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_err", 32'(bus.err), 32'd0);
    reset = 1'b0;

    $display("[TB] filling memory");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 32'(i * 4), $urandom);
    end
    idleBus();

    $display("[TB] directed write/read 0x10");
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    idleBus();
    applyStimulus(1'b1, 1'b0, 32'h10, 32'd0);
    checkOutput("deadbeef", bus.rd, 32'hDEADBEEF);
    idleBus();

    $display("[TB] back-to-back write then read 0x20");
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h11111111);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'd0);
    checkOutput("raw_b2b", bus.rd, 32'h11111111);
    idleBus();

    $display("[TB] reset during WAIT of write 0x40");
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b1;
    bus.addr     = 32'h40;
    bus.wd       = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    checkOutput("abort_busy_before", 32'(bus.busy), 32'd1);
    reset        = 1'b1;
    bus.MemWrite = 1'b0;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    exp_rd = 32'd0;
    checkOutput("abort_ack", 32'(bus.ack), 32'd0);
    checkOutput("abort_busy_after", 32'(bus.busy), 32'd0);
    checkOutput("abort_rd_cleared", bus.rd, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'd0);
    idleBus();

    $display("[TB] address wrap 0x400 -> 0x000");
    applyStimulus(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5);
    applyStimulus(1'b1, 1'b0, 32'h000, 32'd0);
    checkOutput("wrap", bus.rd, 32'hA5A5A5A5);
    idleBus();

    $display("[TB] read and write together at 0x8");
    applyStimulus(1'b1, 1'b1, 32'h8, 32'h5);
    idleBus();
    applyStimulus(1'b1, 1'b0, 32'h8, 32'd0);
    idleBus();

    $display("[TB] write at unaligned 0x13");
    applyStimulus(1'b0, 1'b1, 32'h13, 32'h0BADF00D);
    idleBus();
    applyStimulus(1'b1, 1'b0, 32'h10, 32'd0);
    idleBus();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 120; i++) begin
      op = int'($urandom_range(0, 2));
      a  = $urandom;
      d  = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'(($urandom_range(0, 7)) * 4);
      applyStimulus(op != 1, op != 0, a, d);
      if ($urandom_range(0, 1) == 1) idleBus();
    end
    idleBus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
